// File: rtl/sr_pkg.sv
// sr_pkg: shared state encoding and default word width for the serial deserializer
package sr_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;
endpackage

// File: rtl/serial_deser_if.sv
// serial_deser_if: bit-strobe input side and word/status output side of the deserializer
interface serial_deser_if import sr_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic serial_in;
  logic shift;
  logic start;
  logic ack;
  logic [WIDTH-1:0] Q;
  logic valid;
  logic busy;
  logic overrun;
  modport master(output serial_in, shift, start, ack, input Q, valid, busy, overrun);
  modport slave(input serial_in, shift, start, ack, output Q, valid, busy, overrun);
endinterface

// File: rtl/bit_counter.sv
// bit_counter: received-bit counter; clear with inc set loads 1 for the first bit of a frame
module bit_counter #(parameter int CW = 3) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count
);
  always_ff @(posedge clk)
    count <= clear ? CW'(inc) : count + CW'(inc);
endmodule

// File: rtl/serial_deser.sv
// serial_deser: MSB-first serial-to-parallel word receiver with valid/ack and sticky overrun
module serial_deser import sr_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input  logic     CLK,
  input  logic     reset,
  serial_deser_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] sr, sr_n, q;
  logic load, step, done, clear, inc, valid, overrun;
  always_comb begin
    load    = bus.shift && bus.start;
    step    = bus.shift && !bus.start && state == RECV;
    done    = step && count == CW'(WIDTH - 1);
    state_n = reset ? IDLE : load ? RECV : done ? IDLE : state;
    clear   = reset || load || done;
    inc     = !reset && (load || (step && !done));
    sr_n    = {sr[WIDTH-2:0], bus.serial_in};
  end
  always_ff @(posedge CLK)
    state <= state_n;
  bit_counter #(.CW(CW)) u_cnt (.clk(CLK), .clear(clear), .inc(inc), .count(count));
  // a resync restart leaves q, valid and overrun untouched; only completion writes them
  always_ff @(posedge CLK) begin
    if (reset) begin
      sr      <= '0;
      q       <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) sr <= {{(WIDTH-1){1'b0}}, bus.serial_in};
      else if (step) sr <= sr_n;
      if (done) q <= sr_n;
      valid <= done || (valid && !bus.ack);
      if (done && valid && !bus.ack) overrun <= 1'b1;
    end
  end
  assign bus.Q       = q;
  assign bus.valid   = valid;
  assign bus.busy    = state == RECV;
  assign bus.overrun = overrun;
endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed and random checks of serial_deser against a bit-queue reference model
module tb_serial_deser;
  localparam int W = 4;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  serial_deser_if #(.WIDTH(W)) bus();
  serial_deser #(.WIDTH(W)) dut (.CLK(CLK), .reset(reset), .bus(bus));
  always #5 CLK = ~CLK;
  bit partial[$];
  bit m_busy = 0;
  bit m_valid = 0;
  bit m_ovr = 0;
  logic [W-1:0] m_q = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit si, input bit sh, input bit st, input bit ak, input bit rs);
    bit done;
    logic [W-1:0] w;
    bus.serial_in = si;
    bus.shift = sh;
    bus.start = st;
    bus.ack = ak;
    reset = rs;
    @(posedge CLK);
    done = 0;
    w = '0;
    if (rs) begin
      partial.delete();
      m_busy = 0;
      m_q = '0;
      m_valid = 0;
      m_ovr = 0;
    end else begin
      if (sh && st) begin
        partial.delete();
        partial.push_back(si);
        m_busy = 1;
      end else if (sh && m_busy) begin
        partial.push_back(si);
        if (partial.size() == W) begin
          for (int i = 0; i < W; i++) w = (w << 1) | W'(partial[i]);
          partial.delete();
          m_busy = 0;
          done = 1;
        end
      end
      if (done) begin
        if (m_valid && !ak) m_ovr = 1;
        m_q = w;
        m_valid = 1;
      end else if (ak) m_valid = 0;
    end
    #1;
    chk("Q", 32'(bus.Q), 32'(m_q));
    chk("valid", 32'(bus.valid), 32'(m_valid));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask
  task automatic send(input logic [W-1:0] w, input bit ack_last);
    for (int i = W - 1; i >= 0; i--) cyc(w[i], 1, i == W - 1, ack_last && i == 0, 0);
  endtask
  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 1);
    chk("rst_q", 32'(bus.Q), 0);
    chk("rst_flags", {bus.valid, bus.busy, bus.overrun}, 0);
    send(4'b1011, 0);
    chk("f1_q", 32'(bus.Q), 32'hb);
    chk("f1_vb", {bus.valid, bus.busy}, 2'b10);
    send(4'b0110, 0);
    chk("ovr_q", 32'(bus.Q), 32'h6);
    chk("ovr_flag", {bus.valid, bus.overrun}, 2'b11);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("ovr_sticky", {bus.valid, bus.overrun}, 2'b01);
    chk("q_hold_ack", 32'(bus.Q), 32'h6);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("resync_busy", 32'(bus.busy), 1);
    cyc(0, 1, 0, 0, 0);
    chk("resync_q", 32'(bus.Q), 32'h2);
    chk("resync_ovr", 32'(bus.overrun), 0);
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
    chk("idle_ign", {bus.valid, bus.busy}, 0);
    cyc(1, 1, 1, 0, 0);
    for (int b = 2; b >= 0; b--) begin
      for (int g = 0; g < 3; g++) cyc(1, 0, 1, 0, 0);
      cyc(b == 1, 1, 0, 0, 0);
    end
    chk("gap_q", 32'(bus.Q), 32'ha);
    chk("gap_v", 32'(bus.valid), 1);
    send(4'b1100, 1);
    chk("coinc_q", 32'(bus.Q), 32'hc);
    chk("coinc_vo", {bus.valid, bus.overrun}, 2'b10);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    chk("abort_out", {28'(bus.Q), bus.valid, bus.busy, bus.overrun}, 0);
    cyc(1, 1, 0, 0, 0);
    chk("abort_idle", 32'(bus.busy), 0);
    send(4'b0101, 0);
    chk("post_rst_q", 32'(bus.Q), 32'h5);
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
          $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
